// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: one-outstanding-request imem port feeding a
// small first-word-fall-through queue of (IR, NPC) pairs, flushed by branch redirects.
module mips32_fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int AW       = 10,
    parameter int RESET_PC = 0
) (
    input  logic                       clk1,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [AW-1:0]              imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [AW-1:0]              redirect_pc,
    input  logic                       halt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_ir,
    output logic [31:0]                out_npc,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   fetch_pc, drop_addr;
    logic [31:0]     ir_mem  [DEPTH];
    logic [AW-1:0]   npc_mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q, count_next;
    logic            push, pop, issue_ok;

    // A redirect kills any response arriving in its own cycle.
    assign push = (state == REQ) && imem_ack && !redirect;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_next = redirect ? '0 : CW'(count_q + CW'(push) - CW'(pop));
        issue_ok   = !halt && (count_next < CW'(DEPTH));
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue_ok) state_next = REQ;
            REQ: begin
                if (imem_ack)      state_next = issue_ok ? REQ : IDLE;
                else if (redirect) state_next = DROP;
            end
            DROP: if (imem_ack) state_next = issue_ok ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // In DROP the old address stays on the bus while fetch_pc already holds the target.
    always_comb begin
        imem_req  = (state != IDLE);
        imem_addr = (state == DROP) ? drop_addr : fetch_pc;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= AW'(RESET_PC);
            drop_addr <= AW'(RESET_PC);
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
        end else begin
            count_q <= count_next;
            if (state == REQ && redirect && !imem_ack) drop_addr <= fetch_pc;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + AW'(1);
                    wr_ptr   <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            ir_mem[wr_ptr]  <= imem_rdata;
            npc_mem[wr_ptr] <= fetch_pc + AW'(1);
        end
    end

    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign out_ir    = out_valid ? ir_mem[rd_ptr] : 32'h0;
    assign out_npc   = out_valid ? {{(32-AW){1'b0}}, npc_mem[rd_ptr]} : 32'h0;

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: latency-programmable memory model plus a
// scoreboard of expected (IR, NPC) pairs built from the bench's own fetch-address model.
module tb_mips32_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int LIM   = 200;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect, halt, out_valid, out_ready;
    logic [AW-1:0] redirect_pc;
    logic [31:0]   out_ir, out_npc;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    int wcnt;
    int n;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } exp_t;
    exp_t          q[$];
    logic [AW-1:0] exp_pc;
    logic          drop_flag;
    logic          prev_ok, p_hold, p_halt, p_free;
    logic [AW-1:0] p_addr;

    mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(0)) dut (
        .clk1(clk1), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .out_valid(out_valid),
        .out_ready(out_ready), .out_ir(out_ir), .out_npc(out_npc), .count(count)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {12'hABC, a, ~a};
    endfunction

    // Memory answers after lat wait cycles; lat=0 is zero-wait.
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)                    wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    always @(negedge clk1) begin
        if (!rst_n) begin
            q.delete();
            drop_flag = 1'b0;
            exp_pc    = '0;
            prev_ok   = 1'b0;
        end else begin
            chk("count", 32'(count), 32'(q.size()));
            chk("valid", 32'(out_valid), 32'(q.size() != 0));
            if (prev_ok) begin
                if (p_hold) begin
                    chk("addr_hold", 32'(imem_addr), 32'(p_addr));
                    chk("req_hold", 32'(imem_req), 32'd1);
                end
                if (p_halt && p_free) chk("halt_noreq", 32'(imem_req), 32'd0);
            end
            if (q.size() == DEPTH) chk("full_noreq", 32'(imem_req), 32'd0);
            if (out_valid && out_ready && q.size() != 0) begin
                chk("out_ir", out_ir, q[0].ir);
                chk("out_npc", out_npc, q[0].npc);
                void'(q.pop_front());
            end
            if (imem_ack) begin
                if (redirect || drop_flag) drop_flag = 1'b0;
                else begin
                    chk("ack_addr", 32'(imem_addr), 32'(exp_pc));
                    q.push_back('{mem_word(exp_pc), {22'b0, exp_pc + 10'd1}});
                    exp_pc = exp_pc + 10'd1;
                end
            end
            if (redirect) begin
                q.delete();
                exp_pc    = redirect_pc;
                drop_flag = imem_req && !imem_ack;
            end
            p_hold  = imem_req && !imem_ack;
            p_addr  = imem_addr;
            p_halt  = halt;
            p_free  = !imem_req || imem_ack;
            prev_ok = 1'b1;
        end
    end

    task automatic reset_vals(input string tag);
        chk({tag, "_req"},   32'(imem_req),  32'd0);
        chk({tag, "_addr"},  32'(imem_addr), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ir"},    out_ir,         32'd0);
        chk({tag, "_npc"},   out_npc,        32'd0);
        chk({tag, "_count"}, 32'(count),     32'd0);
    endtask

    task automatic do_reset(input int l, input logic rdy);
        rst_n = 1'b0; redirect = 1'b0; halt = 1'b0;
        lat = l; out_ready = rdy;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
        #3;
        reset_vals("rst");

        // Zero-wait streaming with no gaps.
        do_reset(0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t1_addr", 32'(imem_addr), 32'(k - 1));
            chk("t1_req", 32'(imem_req), 32'd1);
            if (k >= 2) chk("t1_npc", out_npc, 32'(k - 1));
        end

        // Back-pressure fills the queue, then drains in order.
        do_reset(0, 1'b0);
        repeat (8) tick();
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_req", 32'(imem_req), 32'd0);
        chk("t2_addr", 32'(imem_addr), 32'd4);
        chk("t2_head", out_npc, 32'd1);
        out_ready = 1'b1;
        repeat (12) tick();

        // Redirect during a wait cycle: old address held, its data dropped.
        do_reset(3, 1'b1);
        for (n = 0; n < LIM && !(imem_req && imem_addr == 10'd5 && wcnt == 0); n++) tick();
        chk("t3_wait5", 32'(n < LIM), 32'd1);
        redirect = 1'b1; redirect_pc = 10'h040;
        tick();
        redirect = 1'b0;
        chk("t3_hold", 32'(imem_addr), 32'd5);
        for (n = 0; n < LIM && imem_addr == 10'd5; n++) tick();
        chk("t3_newaddr", 32'(imem_addr), 32'h40);
        for (n = 0; n < LIM && !out_valid; n++) tick();
        chk("t3_ir", out_ir, mem_word(10'h040));
        chk("t3_npc", out_npc, 32'h41);
        repeat (10) tick();

        // Redirect, ack and pop in one cycle with two entries queued.
        do_reset(0, 1'b0);
        for (n = 0; n < LIM && count != 3'd2; n++) tick();
        chk("t4_wait2", 32'(n < LIM), 32'd1);
        redirect = 1'b1; redirect_pc = 10'h100; out_ready = 1'b1;
        tick();
        redirect = 1'b0;
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", 32'(imem_addr), 32'h100);
        repeat (10) tick();

        // Address wrap at the top of memory.
        do_reset(0, 1'b0);
        repeat (8) tick();
        redirect = 1'b1; redirect_pc = 10'd1022;
        tick();
        redirect = 1'b0;
        for (n = 0; n < LIM && count != 3'd4; n++) tick();
        chk("t5_npc0", out_npc, 32'd1023);
        chk("t5_ir0", out_ir, mem_word(10'd1022));
        out_ready = 1'b1;
        tick();
        chk("t5_npc1", out_npc, 32'd0);
        chk("t5_ir1", out_ir, mem_word(10'd1023));
        tick();
        chk("t5_npc2", out_npc, 32'd1);
        repeat (6) tick();

        // Halt with a request in flight, then asynchronous reset mid-wait.
        do_reset(3, 1'b1);
        for (n = 0; n < LIM && !(imem_req && wcnt == 0); n++) tick();
        halt = 1'b1;
        for (n = 0; n < LIM && !imem_ack; n++) tick();
        tick();
        chk("t6_pushed", out_ir, mem_word(10'd0));
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t6_noreq", 32'(imem_req), 32'd0);
        end
        halt = 1'b0;
        for (n = 0; n < LIM && !(imem_req && wcnt == 0); n++) tick();
        chk("t6_resume", 32'(imem_addr), 32'd1);
        #2 rst_n = 1'b0;
        #1 reset_vals("t6_rst");
        tick(); tick();
        rst_n = 1'b1;
        for (n = 0; n < LIM && !imem_req; n++) tick();
        chk("t6_first", 32'(imem_addr), 32'd0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
